// File: rtl/fnd_pkg.sv
// Shared types and constants for the multiplexed 7-segment (FND) scan controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: scan FSM state type, active-low glyph constants {g,f,e,d,c,b,a}, off codes.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } fnd_state_t;

    // All segments dark (dp included) / all commons released.
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] COM_OFF   = 8'hFF;
    // Scan runs from the leftmost digit down to digit 0.
    localparam logic [2:0] POS_FIRST = 3'd7;

    // Active-low 7-bit glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/fnd_seg_decode.sv
// Nibble to active-low 7-segment glyph; 0-9 decimal glyphs, 10-15 show a dash.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: nibble (4-bit value in), seg_n (7-bit {g,f,e,d,c,b,a}, active-low out).
module fnd_seg_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    import fnd_pkg::*;

    always_comb begin
        seg_n = GLYPH_BLANK;
        case (nibble)
            4'd0:    seg_n = GLYPH_0;
            4'd1:    seg_n = GLYPH_1;
            4'd2:    seg_n = GLYPH_2;
            4'd3:    seg_n = GLYPH_3;
            4'd4:    seg_n = GLYPH_4;
            4'd5:    seg_n = GLYPH_5;
            4'd6:    seg_n = GLYPH_6;
            4'd7:    seg_n = GLYPH_7;
            4'd8:    seg_n = GLYPH_8;
            4'd9:    seg_n = GLYPH_9;
            default: seg_n = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan: per slot, blank for BLANK_CYC cycles then drive one digit.
// Latency: all outputs registered; slot data is captured on the last blanking cycle edge.
// Backpressure: none; i_en low returns to IDLE on the next cycle, inputs are sampled once per slot.
// Ports: i_clk, i_rst_n (async active-low), i_en, i_bcd[31:0] (digit n = [4n+3:4n]), i_dp[7:0],
//        i_digit_mask[7:0] (1 = shown), o_pos[2:0], o_com[7:0] (active-low), o_seg[7:0]
//        {dp,g,f,e,d,c,b,a} active-low, o_frame_tick (pulse as o_pos wraps 0->7).
// Optional FND_BLINK_EN: adds i_blink_mask[7:0] and BLINK_FRAMES; flagged digits go dark
//        for alternate groups of BLINK_FRAMES frames, starting in the lit phase.
module fnd_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 1000
`ifdef FND_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_bcd,
    input  logic [7:0]  i_dp,
    input  logic [7:0]  i_digit_mask,
`ifdef FND_BLINK_EN
    input  logic [7:0]  i_blink_mask,
`endif
    output logic [2:0]  o_pos,
    output logic [7:0]  o_com,
    output logic [7:0]  o_seg,
    output logic        o_frame_tick
);
    import fnd_pkg::*;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - BLANK_CYC - 1);

    fnd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_d;
    logic [7:0]       com_d;
    logic [7:0]       seg_d;
    logic             tick_d;
    logic [6:0]       dec_seg;
    logic             digit_on;

    // Only one decoder: it always looks at the current position's nibble.
    fnd_seg_decode u_dec (
        .nibble (i_bcd[{o_pos, 2'b00} +: 4]),
        .seg_n  (dec_seg)
    );

`ifdef FND_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] blink_cnt_q;
    logic            blink_off_q;

    // Phase flips after every BLINK_FRAMES completed frames; survives i_en drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (tick_d) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BF_W'(1);
            end
        end
    end

    assign digit_on = i_digit_mask[o_pos] & ~(blink_off_q & i_blink_mask[o_pos]);
`else
    assign digit_on = i_digit_mask[o_pos];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            o_pos        <= POS_FIRST;
            o_com        <= COM_OFF;
            o_seg        <= SEG_OFF;
            o_frame_tick <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_pos        <= pos_d;
            o_com        <= com_d;
            o_seg        <= seg_d;
            o_frame_tick <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = o_pos;
        com_d   = o_com;
        seg_d   = o_seg;
        tick_d  = 1'b0;

        if (!i_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pos_d   = POS_FIRST;
            com_d   = COM_OFF;
            seg_d   = SEG_OFF;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        // Capture data and mask once; they hold for the whole drive phase.
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        seg_d   = {~i_dp[o_pos], dec_seg};
                        com_d   = digit_on ? ~(8'h01 << o_pos) : COM_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        // Leaving digit 0 closes the frame; 3-bit decrement wraps to 7.
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        pos_d   = o_pos - 3'd1;
                        com_d   = COM_OFF;
                        seg_d   = SEG_OFF;
                        tick_d  = (o_pos == 3'd0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE (and any stray code) starts a fresh frame at the leftmost digit.
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    pos_d   = POS_FIRST;
                    com_d   = COM_OFF;
                    seg_d   = SEG_OFF;
                end
            endcase
        end
    end

endmodule
